proj_sched_ctrl: RTL and testbench
==================================

Name: proj_sched_ctrl

Overview:
- Sequencing controller for the 3D→2D camera projection of acoustic source positions.
- Accepts one (x,y,z) point per valid/ready handshake and computes both pixel coordinates on a single shared sequential divider (X first, then Y).
- Applies the pixel rate scaling and clamps the result to the screen.
- Sits between the position solver and the overlay/display writer; replaces per-axis combinational dividers.

Parameters:
- FX, 185, focal scale, X axis
- FY, 185, focal scale, Y axis
- CX, 105, principal point X (sensor units)
- CY, 77, principal point Y (sensor units)
- RATE, 20, sensor-to-pixel scale
- X_MAX, 4159, largest legal x_2d (208*RATE-1)
- Y_MAX, 3119, largest legal y_2d (156*RATE-1)
- DIV_W, 32, numerator/quotient width of the shared divider

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  point available
- in_ready  out  1  controller can accept a point
- x  in  16  unsigned 3D x
- y  in  16  unsigned 3D y
- z  in  16  unsigned 3D z (depth)
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- x_2d  out  16  pixel x
- y_2d  out  16  pixel y
- out_clip  out  1  result was clamped or z==0
- busy  out  1  high in any state other than IDLE

Behaviour:
- One clock domain (clk); reset is synchronous and active-high on rst.
- Reset values:
  - state IDLE; out_valid=0, x_2d=0, y_2d=0, out_clip=0, busy=0; in_ready=1 after reset.
  - rst mid-operation aborts the divider; any pending result is discarded.
- States: IDLE, MAC, DIV_X, DIV_Y, SCALE, OUT.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: latch x,y,z, go to MAC.
  - in_ready is 0 in every other state (no overlap between points).
- MAC (1 cycle):
  - nx = FX*x + CX*z; ny = FY*y + CY*z; both DIV_W bits unsigned, no overflow for 16-bit inputs.
  - If z==0: load x_2d=0, y_2d=0, out_clip=1, go to OUT (out_valid at accept edge +2).
  - Otherwise start divider with nx/z and go to DIV_X.
- DIV_X: wait for divider done, store qx, start divider with ny/z, go to DIV_Y.
- DIV_Y: wait for done, store qy, go to SCALE.
- SCALE (1 cycle):
  - px = qx*RATE, py = qy*RATE, computed at DIV_W+8 bits.
  - x_2d = min(px, X_MAX); y_2d = min(py, Y_MAX).
  - out_clip = 1 if either axis was clamped.
  - Go to OUT.
- OUT:
  - out_valid=1; outputs held stable until out_ready sampled high.
  - On handshake: out_valid=0 on the next cycle, return to IDLE.
- Fixed latency: for z≠0, out_valid rises exactly 2*DIV_W+6 = 70 cycles after the accepting edge.
- Divider: restoring unsigned, one quotient bit per cycle; done pulses exactly DIV_W+1 cycles after start.
- Division truncates (floor); scaling is applied after division.
- If in_valid is dropped before acceptance, nothing happens. Input values are sampled only on the accepting edge.

Optional Feature:
- Macro PROJ_ROUND_EN.
- Defined: numerator becomes nx + (z>>1) (likewise ny), giving round-half-up quotients. Latency unchanged.
- Undefined: floor division as above.

Decomposition:
- Package proj_pkg holds:
  - state enum proj_state_t;
  - default constants FX, FY, CX, CY, RATE, X_MAX, Y_MAX, DIV_W;
  - localparam LATENCY = 2*DIV_W+6.
- One sub-module: proj_seq_udiv (start/done, dividend, divisor, quotient; DIV_W parameter), instantiated once and shared by both axes.

Test Plan:
- x=10, y=10, z=100, out_ready=1 → out_valid 70 cycles after accept; x_2d=2460, y_2d=1900, out_clip=0. With PROJ_ROUND_EN: 2480, 1920.
- x=0, y=0, z=1 → x_2d=2100, y_2d=1540, out_clip=0.
- x=100, y=100, z=100 → x_2d=4159, y_2d=3119, out_clip=1.
- z=0, any x/y → out_valid 2 cycles after accept; x_2d=0, y_2d=0, out_clip=1.
- Backpressure: out_ready held 0 for 10 cycles with a second point presented:
  - outputs stable and in_ready=0 throughout;
  - second point accepted only after the out handshake;
  - second result correct.
- rst asserted 20 cycles into DIV_X → next cycle state IDLE, out_valid=0, busy=0, in_ready=1; a fresh point then completes with correct results and 70-cycle latency.

Source files
------------

// File: rtl/proj_pkg.sv
// Shared types and default constants for the camera projection sequencer.
package proj_pkg;

  localparam int FX      = 185;
  localparam int FY      = 185;
  localparam int CX      = 105;
  localparam int CY      = 77;
  localparam int RATE    = 20;
  localparam int X_MAX   = 4159;
  localparam int Y_MAX   = 3119;
  localparam int DIV_W   = 32;
  localparam int LATENCY = 2 * DIV_W + 6;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MAC,
    ST_DIV_X,
    ST_DIV_Y,
    ST_SCALE,
    ST_OUT
  } proj_state_t;

endpackage

// File: rtl/proj_sched_ctrl_if.sv
// Point-in / pixel-out bundle between the position solver and the display writer.
// Handshake: a transfer happens on a rising clk edge where valid && ready; the
// sender holds valid and its data stable until that edge and never waits on ready.
interface proj_sched_ctrl_if;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] x;
  logic [15:0] y;
  logic [15:0] z;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] x_2d;
  logic [15:0] y_2d;
  logic        out_clip;

  modport master (
    output in_valid, x, y, z, out_ready,
    input  in_ready, out_valid, x_2d, y_2d, out_clip
  );

  modport slave (
    input  in_valid, x, y, z, out_ready,
    output in_ready, out_valid, x_2d, y_2d, out_clip
  );
endinterface

// File: rtl/proj_seq_udiv.sv
// Restoring unsigned divider, one quotient bit per clock; done is a one-cycle
// pulse DIV_W+1 cycles after start, with quotient valid while done is high.
module proj_seq_udiv #(
  parameter int DIV_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [DIV_W-1:0] dividend,
  input  logic [DIV_W-1:0] divisor,
  output logic [DIV_W-1:0] quotient,
  output logic             done
);
  localparam int CW = $clog2(DIV_W + 1);

  logic             active_q, active_d;
  logic             done_q, done_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [DIV_W-1:0] rem_q, rem_d;
  logic [DIV_W-1:0] quo_q, quo_d;
  logic [DIV_W-1:0] dvs_q, dvs_d;
  logic [DIV_W:0]   rem_sh;

  // The dividend shifts out of quo_q MSB-first while quotient bits shift in.
  assign rem_sh = {rem_q, quo_q[DIV_W-1]};

  always_comb begin
    active_d = active_q;
    done_d   = 1'b0;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvs_d    = dvs_q;
    if (start && !active_q) begin
      active_d = 1'b1;
      cnt_d    = CW'(DIV_W);
      rem_d    = '0;
      quo_d    = dividend;
      dvs_d    = divisor;
    end else if (active_q) begin
      if (rem_sh >= {1'b0, dvs_q}) begin
        rem_d = rem_sh[DIV_W-1:0] - dvs_q;
        quo_d = {quo_q[DIV_W-2:0], 1'b1};
      end else begin
        rem_d = rem_sh[DIV_W-1:0];
        quo_d = {quo_q[DIV_W-2:0], 1'b0};
      end
      cnt_d = cnt_q - CW'(1);
      if (cnt_q == CW'(1)) begin
        active_d = 1'b0;
        done_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      active_q <= 1'b0;
      done_q   <= 1'b0;
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
    end else begin
      active_q <= active_d;
      done_q   <= done_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvs_q    <= dvs_d;
    end
  end

  assign quotient = quo_q;
  assign done     = done_q;
endmodule

// File: rtl/proj_sched_ctrl.sv
// Projects one (x,y,z) point to clamped pixel coordinates using one shared divider.
// Define PROJ_ROUND_EN to bias numerators by z/2 for round-half-up quotients.
module proj_sched_ctrl
  import proj_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  proj_sched_ctrl_if.slave io,
  output logic             busy,
  output proj_state_t      dbg_state
);
  localparam int PW = DIV_W + 8;

  proj_state_t      state_q, state_d;
  logic [15:0]      x_q, x_d, y_q, y_d, z_q, z_d;
  logic [DIV_W-1:0] nx_q, nx_d, ny_q, ny_d, qx_q, qx_d, qy_q, qy_d;
  logic [15:0]      x_2d_q, x_2d_d, y_2d_q, y_2d_d;
  logic             start_q, start_d, out_valid_q, out_valid_d, clip_q, clip_d;
  logic             busy_q, busy_d, in_ready_q, in_ready_d;
  logic [DIV_W-1:0] rnd_c, nx_c, ny_c, div_num, div_quo;
  logic             div_done;
  logic [PW-1:0]    px_c, py_c;
  logic             clip_x, clip_y;

`ifdef PROJ_ROUND_EN
  assign rnd_c = DIV_W'(z_q >> 1);
`else
  assign rnd_c = '0;
`endif

  assign nx_c = DIV_W'(FX) * DIV_W'(x_q) + DIV_W'(CX) * DIV_W'(z_q) + rnd_c;
  assign ny_c = DIV_W'(FY) * DIV_W'(y_q) + DIV_W'(CY) * DIV_W'(z_q) + rnd_c;

  // start_q is high in the first cycle of DIV_X / DIV_Y, so the state selects the numerator.
  assign div_num = (state_q == ST_DIV_Y) ? ny_q : nx_q;

  proj_seq_udiv #(.DIV_W(DIV_W)) u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (start_q),
    .dividend (div_num),
    .divisor  (DIV_W'(z_q)),
    .quotient (div_quo),
    .done     (div_done)
  );

  assign px_c   = PW'(qx_q) * PW'(RATE);
  assign py_c   = PW'(qy_q) * PW'(RATE);
  assign clip_x = px_c > PW'(X_MAX);
  assign clip_y = py_c > PW'(Y_MAX);

  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    z_d         = z_q;
    nx_d        = nx_q;
    ny_d        = ny_q;
    qx_d        = qx_q;
    qy_d        = qy_q;
    x_2d_d      = x_2d_q;
    y_2d_d      = y_2d_q;
    clip_d      = clip_q;
    start_d     = 1'b0;
    out_valid_d = out_valid_q;
    case (state_q)
      ST_IDLE: begin
        if (io.in_valid && in_ready_q) begin
          x_d     = io.x;
          y_d     = io.y;
          z_d     = io.z;
          state_d = ST_MAC;
        end
      end
      ST_MAC: begin
        nx_d = nx_c;
        ny_d = ny_c;
        if (z_q == 16'd0) begin
          x_2d_d  = 16'd0;
          y_2d_d  = 16'd0;
          clip_d  = 1'b1;
          state_d = ST_OUT;
        end else begin
          start_d = 1'b1;
          state_d = ST_DIV_X;
        end
      end
      ST_DIV_X: begin
        if (div_done) begin
          qx_d    = div_quo;
          start_d = 1'b1;
          state_d = ST_DIV_Y;
        end
      end
      ST_DIV_Y: begin
        if (div_done) begin
          qy_d    = div_quo;
          state_d = ST_SCALE;
        end
      end
      ST_SCALE: begin
        x_2d_d      = clip_x ? 16'(X_MAX) : px_c[15:0];
        y_2d_d      = clip_y ? 16'(Y_MAX) : py_c[15:0];
        clip_d      = clip_x | clip_y;
        out_valid_d = 1'b1;
        state_d     = ST_OUT;
      end
      ST_OUT: begin
        // Entered from MAC with valid low, so the z==0 result appears one cycle later.
        if (out_valid_q && io.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end else begin
          out_valid_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    in_ready_d = (state_d == ST_IDLE);
    busy_d     = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      x_q         <= '0;
      y_q         <= '0;
      z_q         <= '0;
      nx_q        <= '0;
      ny_q        <= '0;
      qx_q        <= '0;
      qy_q        <= '0;
      x_2d_q      <= '0;
      y_2d_q      <= '0;
      clip_q      <= 1'b0;
      start_q     <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      z_q         <= z_d;
      nx_q        <= nx_d;
      ny_q        <= ny_d;
      qx_q        <= qx_d;
      qy_q        <= qy_d;
      x_2d_q      <= x_2d_d;
      y_2d_q      <= y_2d_d;
      clip_q      <= clip_d;
      start_q     <= start_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign io.in_ready  = in_ready_q;
  assign io.out_valid = out_valid_q;
  assign io.x_2d      = x_2d_q;
  assign io.y_2d      = y_2d_q;
  assign io.out_clip  = clip_q;
  assign busy         = busy_q;
  assign dbg_state    = state_q;
endmodule

// File: tb/tb_proj_sched_ctrl.sv
// Scoreboard bench for proj_sched_ctrl: reference projection model, latency,
// hold-under-backpressure and mid-operation reset checks.
module tb_proj_sched_ctrl;
  import proj_pkg::*;

  localparam int W   = 33;
  localparam int LAT = 70;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        busy;
  proj_state_t dbg_state;

  proj_sched_ctrl_if io();

  proj_sched_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .io        (io),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: sim time %0t exceeded limit", $time);
    $fatal(1);
  end

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  int           lat_q[$];
  int           acc_q[$];
  int           n_tests = 0;
  int           n_fail  = 0;
  int           last_acc = 0;
  int           last_hs  = 0;
  logic         ov_prev  = 1'b0;
  logic [W-1:0] held     = '0;
  logic [W-1:0] obs_v, exp_v;
  int           lat_exp, acc_edge;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference projection: {clip, x_2d, y_2d}
  function automatic logic [W-1:0] model(input logic [15:0] mx, my, mz);
    longint nx, ny, px, py;
    logic   cx, cy;
    if (mz == 16'd0) return {1'b1, 32'd0};
    nx = 185 * longint'(mx) + 105 * longint'(mz);
    ny = 185 * longint'(my) + 77 * longint'(mz);
`ifdef PROJ_ROUND_EN
    nx = nx + longint'(mz) / 2;
    ny = ny + longint'(mz) / 2;
`endif
    px = (nx / longint'(mz)) * 20;
    py = (ny / longint'(mz)) * 20;
    cx = px > 4159;
    cy = py > 3119;
    if (cx) px = 4159;
    if (cy) py = 3119;
    return {cx | cy, 16'(px), 16'(py)};
  endfunction

  // ---------------- output monitor ----------------
  always @(negedge clk) begin
    if (rst) begin
      ov_prev = 1'b0;
    end else begin
      obs_v = {io.out_clip, io.x_2d, io.y_2d};
      if (io.out_valid) check("in_ready_while_out", io.in_ready, 0);
      if (io.out_valid && !ov_prev) begin
        if (lat_q.size() == 0) begin
          check("unexpected_valid", 1, 0);
        end else begin
          lat_exp  = lat_q.pop_front();
          acc_edge = acc_q.pop_front();
          check("latency", cyc - acc_edge, lat_exp);
        end
      end
      if (io.out_valid && ov_prev) check("hold_stable", obs_v, held);
      if (io.out_valid && io.out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out", 1, 0);
        end else begin
          exp_v = exp_q.pop_front();
          check("x_2d", io.x_2d, exp_v[31:16]);
          check("y_2d", io.y_2d, exp_v[15:0]);
          check("out_clip", io.out_clip, exp_v[32]);
        end
        last_hs = cyc + 1;
      end
      ov_prev = io.out_valid;
      held    = obs_v;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_point(input logic [15:0] px, py, pz);
    int budget;
    budget = 400;
    @(posedge clk); #1;
    io.in_valid = 1'b1;
    io.x = px;
    io.y = py;
    io.z = pz;
    while (!io.in_ready && budget > 0) begin
      @(posedge clk); #1;
      budget--;
    end
    if (budget == 0) begin
      check("accept_timeout", 0, 1);
      io.in_valid = 1'b0;
      return;
    end
    last_acc = cyc + 1;
    exp_q.push_back(model(px, py, pz));
    lat_q.push_back((pz == 16'd0) ? 2 : LAT);
    acc_q.push_back(cyc + 1);
    @(posedge clk); #1;
    io.in_valid = 1'b0;
    io.x = 16'($urandom);
    io.y = 16'($urandom);
    io.z = 16'($urandom);
  endtask

  task automatic wait_drain();
    int budget;
    budget = 2000;
    while ((exp_q.size() != 0 || io.out_valid) && budget > 0) begin
      @(posedge clk); #1;
      budget--;
    end
    if (budget == 0) check("drain_timeout", 0, 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int b;
    io.in_valid  = 1'b0;
    io.x         = '0;
    io.y         = '0;
    io.z         = '0;
    io.out_ready = 1'b1;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_state", dbg_state, ST_IDLE);
    check("rst_out_valid", io.out_valid, 0);
    check("rst_x_2d", io.x_2d, 0);
    check("rst_y_2d", io.y_2d, 0);
    check("rst_out_clip", io.out_clip, 0);
    check("rst_busy", busy, 0);
    check("rst_in_ready", io.in_ready, 1);

    // Test plan points and boundaries
    send_point(16'd10, 16'd10, 16'd100);       wait_drain();
    send_point(16'd0, 16'd0, 16'd1);           wait_drain();
    send_point(16'd100, 16'd100, 16'd100);     wait_drain();
    send_point(16'd1234, 16'd777, 16'd0);      wait_drain();
    send_point(16'hFFFF, 16'hFFFF, 16'hFFFF);  wait_drain();
    send_point(16'd0, 16'd0, 16'hFFFF);        wait_drain();
    send_point(16'hFFFF, 16'd0, 16'd1);        wait_drain();

    // Backpressure with a second point waiting
    io.out_ready = 1'b0;
    send_point(16'd10, 16'd10, 16'd100);
    fork
      send_point(16'd20, 16'd30, 16'd40);
      begin
        b = 200;
        while (!io.out_valid && b > 0) begin
          @(posedge clk); #1;
          b--;
        end
        check("bp_valid_seen", io.out_valid, 1);
        repeat (10) begin
          @(posedge clk); #1;
          check("bp_in_ready_low", io.in_ready, 0);
        end
        io.out_ready = 1'b1;
      end
    join
    check("bp_accept_after_hs", last_acc - last_hs, 1);
    wait_drain();

    // Reset 20 cycles into DIV_X
    send_point(16'd300, 16'd200, 16'd50);
    b = 200;
    while (dbg_state != ST_DIV_X && b > 0) begin
      @(posedge clk); #1;
      b--;
    end
    check("reach_div_x", dbg_state, ST_DIV_X);
    repeat (20) @(posedge clk);
    #1 rst = 1'b1;
    exp_q.delete();
    lat_q.delete();
    acc_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_state", dbg_state, ST_IDLE);
    check("abort_out_valid", io.out_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_in_ready", io.in_ready, 1);
    send_point(16'd10, 16'd10, 16'd100);
    wait_drain();

    // Random points, back to back
    for (int i = 0; i < 8; i++) begin
      send_point(16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)),
                 (i % 4 == 0) ? 16'd0 : 16'($urandom_range(1, 65535)));
    end
    for (int i = 0; i < 4; i++) begin
      send_point(16'($urandom_range(0, 200)), 16'($urandom_range(0, 200)),
                 16'($urandom_range(50, 400)));
    end
    wait_drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
